// File: rtl/bus_trace_monitor.sv
// Data-memory bus monitor: traces CPU stores into a FIFO and reports pass/fail
// on a completion store or cycle timeout. Define INSTR_TRACE_EN for instruction capture and spin detection.
module bus_trace_monitor #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 16,
  parameter int                TIMEOUT   = 1024,
  parameter logic [ADDR_W-1:0] DONE_ADDR = ADDR_W'(32'h64),
  parameter logic [DATA_W-1:0] DONE_DATA = DATA_W'(32'd7)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             mem_write,
  input  logic [ADDR_W-1:0]                data_adr,
  input  logic [DATA_W-1:0]                write_data,
`ifdef INSTR_TRACE_EN
  input  logic [31:0]                      instr,
  output logic [31:0]                      pop_instr,
`endif
  input  logic                             pop_ready,
  output logic                             pop_valid,
  output logic [ADDR_W-1:0]                pop_adr,
  output logic [DATA_W-1:0]                pop_data,
  output logic [$clog2(TIMEOUT+1)-1:0]     pop_cycle,
  output logic [1:0]                       state,
  output logic                             done,
  output logic                             overflow,
  output logic [15:0]                      write_count
);

  localparam int CW = $clog2(TIMEOUT+1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_PASS = 2'b10,
    S_FAIL = 2'b11
  } state_t;

  state_t            r_state, w_nextState;
  logic [CW-1:0]     r_cycle;
  logic [15:0]       r_writeCount;
  logic              r_overflow;
  logic [PW-1:0]     r_wrPtr, r_rdPtr;
  logic [ADDR_W-1:0] r_memAdr   [DEPTH];
  logic [DATA_W-1:0] r_memData  [DEPTH];
  logic [CW-1:0]     r_memCycle [DEPTH];
  logic [ADDR_W-1:0] r_popAdr;
  logic [DATA_W-1:0] r_popData;
  logic [CW-1:0]     r_popCycle;

  logic          w_run, w_empty, w_full, w_pop, w_store, w_push, w_drop;
  logic          w_doneHit, w_timeout, w_spin, w_headValid, w_headNew;
  logic [PW-1:0] w_rdNext, w_wrNext;

  assign w_run       = (r_state == S_RUN);
  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_full      = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop       = !w_empty && pop_ready;
  assign w_store     = w_run && mem_write;
  assign w_push      = w_store && (!w_full || w_pop);
  assign w_drop      = w_store && w_full && !w_pop;
  assign w_rdNext    = r_rdPtr + PW'(w_pop);
  assign w_wrNext    = r_wrPtr + PW'(w_push);
  assign w_headValid = (w_wrNext != w_rdNext);
  // The new head bypasses the memory when it is the entry being written this edge.
  assign w_headNew   = w_push && (r_wrPtr[AW-1:0] == w_rdNext[AW-1:0]);
  assign w_doneHit   = w_store && (data_adr == DONE_ADDR);
  assign w_timeout   = (r_cycle == CW'(TIMEOUT-1));

`ifdef INSTR_TRACE_EN
  localparam logic [31:0] SPIN_INSTR = 32'hEAFFFFFE;

  logic [1:0]  r_spinCnt;
  logic [31:0] r_memInstr [DEPTH];
  logic [31:0] r_popInstr;

  assign w_spin    = w_run && (instr == SPIN_INSTR) && (r_spinCnt == 2'd3);
  assign pop_instr = r_popInstr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_spinCnt <= 2'd0;
    end else if (w_run && (instr == SPIN_INSTR)) begin
      r_spinCnt <= (r_spinCnt == 2'd3) ? 2'd3 : r_spinCnt + 2'd1;
    end else begin
      r_spinCnt <= 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memInstr[r_wrPtr[AW-1:0]] <= instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_popInstr <= '0;
    end else if (w_headValid) begin
      r_popInstr <= w_headNew ? instr : r_memInstr[w_rdNext[AW-1:0]];
    end
  end
`else
  assign w_spin = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A completion store's verdict takes priority over timeout and spin detection.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (w_doneHit) begin
          w_nextState = (write_data == DONE_DATA) ? S_PASS : S_FAIL;
        end else if (w_timeout || w_spin) begin
          w_nextState = S_FAIL;
        end
      end
      default: w_nextState = r_state;
    endcase
  end

  // The counter stops on the verdict edge so the stamp never exceeds TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle      <= '0;
      r_writeCount <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_run && (w_nextState == S_RUN)) begin
        r_cycle <= r_cycle + CW'(1);
      end
      if (w_store && (r_writeCount != 16'hFFFF)) begin
        r_writeCount <= r_writeCount + 16'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      r_wrPtr <= w_wrNext;
      r_rdPtr <= w_rdNext;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memAdr[r_wrPtr[AW-1:0]]   <= data_adr;
      r_memData[r_wrPtr[AW-1:0]]  <= write_data;
      r_memCycle[r_wrPtr[AW-1:0]] <= r_cycle;
    end
  end

  // Head registers hold their last value once the FIFO runs empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_popAdr   <= '0;
      r_popData  <= '0;
      r_popCycle <= '0;
    end else if (w_headValid) begin
      r_popAdr   <= w_headNew ? data_adr   : r_memAdr[w_rdNext[AW-1:0]];
      r_popData  <= w_headNew ? write_data : r_memData[w_rdNext[AW-1:0]];
      r_popCycle <= w_headNew ? r_cycle    : r_memCycle[w_rdNext[AW-1:0]];
    end
  end

  assign pop_valid   = !w_empty;
  assign pop_adr     = r_popAdr;
  assign pop_data    = r_popData;
  assign pop_cycle   = r_popCycle;
  assign state       = r_state;
  assign done        = (r_state == S_PASS) || (r_state == S_FAIL);
  assign overflow    = r_overflow;
  assign write_count = r_writeCount;

endmodule

// File: tb/tb_bus_trace_monitor.sv
// Directed self-checking bench for bus_trace_monitor (DEPTH=4, TIMEOUT=8).
module tb_bus_trace_monitor;

  logic        clk = 1'b0;
  logic        reset, en, mem_write, pop_ready;
  logic [31:0] data_adr, write_data;
  logic        pop_valid, done, overflow;
  logic [31:0] pop_adr, pop_data;
  logic [3:0]  pop_cycle;
  logic [1:0]  state;
  logic [15:0] write_count;
`ifdef INSTR_TRACE_EN
  logic [31:0] instr, pop_instr;
`endif

  int checks = 0;
  int failures = 0;

  bus_trace_monitor #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4), .TIMEOUT(8),
    .DONE_ADDR(32'h64), .DONE_DATA(32'd7)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
`ifdef INSTR_TRACE_EN
    .instr(instr), .pop_instr(pop_instr),
`endif
    .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_adr(pop_adr),
    .pop_data(pop_data), .pop_cycle(pop_cycle), .state(state), .done(done),
    .overflow(overflow), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] adr, input logic [31:0] dat);
    mem_write  = wr;
    data_adr   = adr;
    write_data = dat;
    tick();
  endtask

  task automatic resetAndStart();
    en = 1'b0; mem_write = 1'b0; pop_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    reset = 1'b0;
    pop_ready = 1'b0;
`ifdef INSTR_TRACE_EN
    instr = 32'h0;
`endif
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); mem_write = 1'($urandom);
      data_adr = $urandom; write_data = $urandom; pop_ready = 1'($urandom);
      tick();
    end
    checkOutput("rst_state", 64'(state), 64'h0);
    checkOutput("rst_pop_valid", 64'(pop_valid), 64'h0);
    checkOutput("rst_overflow", 64'(overflow), 64'h0);
    checkOutput("rst_write_count", 64'(write_count), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h0);
    checkOutput("rst_pop_adr", 64'(pop_adr), 64'h0);
    checkOutput("rst_pop_cycle", 64'(pop_cycle), 64'h0);

    // Store in IDLE is ignored, then en starts RUN
    reset = 1'b1; en = 1'b0; pop_ready = 1'b0;
    applyStimulus(1'b1, 32'h40, 32'h1);
    checkOutput("idle_store_ignored", 64'(pop_valid), 64'h0);
    mem_write = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    checkOutput("enter_run", 64'(state), 64'h1);

    // Two stores then passing completion store
    applyStimulus(1'b1, 32'h10, 32'd3);
    checkOutput("first_push_visible", 64'(pop_valid), 64'h1);
    applyStimulus(1'b1, 32'h14, 32'd5);
    applyStimulus(1'b1, 32'h64, 32'd7);
    checkOutput("pass_state", 64'(state), 64'h2);
    checkOutput("pass_done", 64'(done), 64'h1);
    checkOutput("pass_wcount", 64'(write_count), 64'd3);
    checkOutput("head0", {pop_adr, pop_data}, {32'h10, 32'd3});
    checkOutput("head0_cycle", 64'(pop_cycle), 64'd0);
    mem_write = 1'b0; en = 1'b1; pop_ready = 1'b1;
    tick();
    checkOutput("head1", {pop_adr, pop_data}, {32'h14, 32'd5});
    checkOutput("head1_cycle", 64'(pop_cycle), 64'd1);
    tick();
    checkOutput("head2", {pop_adr, pop_data}, {32'h64, 32'd7});
    checkOutput("head2_cycle", 64'(pop_cycle), 64'd2);
    tick();
    checkOutput("drained_valid", 64'(pop_valid), 64'h0);
    checkOutput("empty_hold_adr", 64'(pop_adr), 64'h64);
    checkOutput("pass_terminal", 64'(state), 64'h2);

    // Wrong completion data fails; later stores not captured
    resetAndStart();
    applyStimulus(1'b1, 32'h64, 32'd9);
    checkOutput("fail_state", 64'(state), 64'h3);
    checkOutput("fail_done", 64'(done), 64'h1);
    applyStimulus(1'b1, 32'h20, 32'd1);
    checkOutput("fail_wcount", 64'(write_count), 64'd1);
    checkOutput("fail_head", {pop_adr, pop_data}, {32'h64, 32'd9});
    mem_write = 1'b0; pop_ready = 1'b1;
    tick();
    checkOutput("fail_no_more", 64'(pop_valid), 64'h0);

    // Overflow: six stores into a four-entry FIFO
    resetAndStart();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1));
    end
    mem_write = 1'b0;
    checkOutput("ovf_flag", 64'(overflow), 64'h1);
    checkOutput("ovf_wcount", 64'(write_count), 64'd6);
    checkOutput("ovf_head", {pop_adr, pop_data}, {32'h100, 32'd1});
    pop_ready = 1'b1;
    tick();
    checkOutput("ovf_pop1", {pop_adr, pop_data}, {32'h104, 32'd2});
    tick();
    tick();
    checkOutput("ovf_pop3", {pop_adr, pop_data}, {32'h10C, 32'd4});
    checkOutput("ovf_pop3_cycle", 64'(pop_cycle), 64'd3);
    tick();
    checkOutput("ovf_four_kept", 64'(pop_valid), 64'h0);

    // Push and pop on the same edge while full
    resetAndStart();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'(i + 1));
    end
    checkOutput("full_no_ovf", 64'(overflow), 64'h0);
    pop_ready = 1'b1;
    applyStimulus(1'b1, 32'h210, 32'd5);
    mem_write = 1'b0;
    checkOutput("fullpp_no_ovf", 64'(overflow), 64'h0);
    checkOutput("fullpp_wcount", 64'(write_count), 64'd5);
    checkOutput("fullpp_head", 64'(pop_adr), 64'h204);
    tick();
    tick();
    tick();
    checkOutput("fullpp_last", {pop_adr, pop_data}, {32'h210, 32'd5});
    checkOutput("fullpp_last_cycle", 64'(pop_cycle), 64'd4);
    tick();
    checkOutput("fullpp_empty", 64'(pop_valid), 64'h0);

    // Timeout with no stores
    resetAndStart();
    for (int i = 0; i < 7; i++) tick();
    checkOutput("tmo_still_run", 64'(state), 64'h1);
    tick();
    checkOutput("tmo_fail", 64'(state), 64'h3);
    checkOutput("tmo_wcount", 64'(write_count), 64'h0);

    // Completion store on the last RUN cycle wins over timeout
    resetAndStart();
    for (int i = 0; i < 7; i++) tick();
    applyStimulus(1'b1, 32'h64, 32'd7);
    mem_write = 1'b0;
    checkOutput("tmo_store_pass", 64'(state), 64'h2);
    checkOutput("tmo_store_cycle", 64'(pop_cycle), 64'd7);

    // Reset discards trace contents
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("rst_discard_valid", 64'(pop_valid), 64'h0);
    checkOutput("rst_discard_adr", 64'(pop_adr), 64'h0);
    checkOutput("rst_discard_state", 64'(state), 64'h0);

`ifdef INSTR_TRACE_EN
    // Branch-to-self for four edges fails the run
    resetAndStart();
    instr = 32'hEAFFFFFE;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("spin_still_run", 64'(state), 64'h1);
    tick();
    checkOutput("spin_fail", 64'(state), 64'h3);
    instr = 32'h0;

    // Instruction captured with the store
    resetAndStart();
    instr = 32'hE5812000;
    applyStimulus(1'b1, 32'h30, 32'd1);
    mem_write = 1'b0;
    instr = 32'h0;
    checkOutput("pop_instr", 64'(pop_instr), 64'hE5812000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
